// File: rtl/instr_encoder.sv
// Encodes LW/SW/ALU/BEQ/BNE/J requests into 32-bit words and queues them, with sequential addresses, in a 4-deep FIFO.
// Define INSTR_ENC_CHECK_EN to reject opcodes 13-15 and raise the sticky err flag; otherwise they encode as ALU words.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [2:0]        level,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [5:0] OPC_BEQ     = 6'b001011;
    localparam logic [5:0] OPC_BNE     = 6'b001100;
    localparam logic [5:0] OPC_J       = 6'b001101;
    localparam logic [5:0] OPC_ILL_ALU = 6'b000010;
    localparam logic [2:0] DEPTH       = 3'd4;

    logic [31:0]       mem_q [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        err_set;

    always_comb begin
        enc_word = '0;
        case (req_op)
            4'd0, 4'd1:
                enc_word = {2'b00, req_op, req_rs, req_rt, req_imm};
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                enc_word = {2'b00, req_op, req_rs, req_rt, req_rd, 11'b0};
            4'd10:
                enc_word = {OPC_BEQ, req_rs, req_rt, req_imm};
            4'd11:
                enc_word = {OPC_BNE, req_rs, req_rt, req_imm};
            4'd12:
                enc_word = {OPC_J, req_target};
            default:
                enc_word = {OPC_ILL_ALU, req_rs, req_rt, req_rd, 11'b0};
        endcase
    end

    assign req_ready = (count_q != DEPTH);
    assign out_valid = (count_q != 3'd0);
    assign accept    = req_valid && req_ready;
    assign pop       = out_valid && out_ready;

`ifdef INSTR_ENC_CHECK_EN
    logic illegal;
    assign illegal = (req_op > 4'd12);
    assign push    = accept && !illegal;
    assign err_set = accept && illegal;
`else
    assign push    = accept;
    assign err_set = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            addr_d   = addr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        // Set takes priority over a same-cycle clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign out_word = mem_q[rd_ptr_q];
    assign out_addr = addr_q;
    assign level    = count_q;
    assign err      = err_q;

endmodule
